// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - sync-framed command decoder with XOR checksum and intra-frame timeout
module uart_frame_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 33_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  cmd_addr,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        err_checksum,
    output logic        err_timeout,
    output logic [7:0]  error_count
);

    localparam int              CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]   TMO_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_OUT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_idx;
    logic [7:0]    r_chk;
    logic [CW-1:0] r_tmo;
    logic [7:0]    r_addr;
    logic [31:0]   r_data;
    logic          r_err_chk;
    logic          r_err_tmo;
    logic [7:0]    r_err_cnt;

    logic          w_accept;
    logic          w_in_frame;
    logic          w_tmo_expire;
    logic          w_chk_bad;

    assign w_in_frame   = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_CHK);
    assign w_accept     = in_valid && in_ready;
    // An accepted byte on the limit cycle takes priority over the timeout.
    assign w_tmo_expire = w_in_frame && !w_accept && (r_tmo == TMO_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_chk_bad = 1'b0;
        in_ready  = 1'b1;
        cmd_valid = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_accept && (in_data == SYNC_BYTE)) begin
                    w_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_accept) begin
                    w_next = ST_DATA;
                end else if (w_tmo_expire) begin
                    w_next = ST_HUNT;
                end
            end
            ST_DATA: begin
                if (w_accept && (r_idx == 2'd3)) begin
                    w_next = ST_CHK;
                end else if (w_tmo_expire) begin
                    w_next = ST_HUNT;
                end
            end
            ST_CHK: begin
                if (w_accept) begin
                    if (in_data == r_chk) begin
                        w_next = ST_OUT;
                    end else begin
                        w_next    = ST_HUNT;
                        w_chk_bad = 1'b1;
                    end
                end else if (w_tmo_expire) begin
                    w_next = ST_HUNT;
                end
            end
            ST_OUT: begin
                in_ready  = 1'b0;
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    w_next = ST_HUNT;
                end
            end
            default: begin
                w_next = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx  <= 2'd0;
            r_chk  <= 8'h00;
            r_addr <= 8'h00;
            r_data <= 32'h0;
        end else if (w_accept) begin
            case (r_state)
                ST_HUNT: begin
                    if (in_data == SYNC_BYTE) begin
                        r_chk <= SYNC_BYTE;
                    end
                end
                ST_ADDR: begin
                    r_addr <= in_data;
                    r_chk  <= r_chk ^ in_data;
                    r_idx  <= 2'd0;
                end
                ST_DATA: begin
                    r_data[8*r_idx +: 8] <= in_data;
                    r_chk                <= r_chk ^ in_data;
                    r_idx                <= r_idx + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Idle counter: any accepted byte, leaving the frame states, or expiry restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo <= '0;
        end else if (w_in_frame && !w_accept && !w_tmo_expire) begin
            r_tmo <= r_tmo + CW'(1);
        end else begin
            r_tmo <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_chk <= 1'b0;
            r_err_tmo <= 1'b0;
            r_err_cnt <= 8'h00;
        end else begin
            r_err_chk <= w_chk_bad;
            r_err_tmo <= w_tmo_expire;
            if ((w_chk_bad || w_tmo_expire) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign cmd_addr     = r_addr;
    assign cmd_data     = r_data;
    assign err_checksum = r_err_chk;
    assign err_timeout  = r_err_tmo;
    assign error_count  = r_err_cnt;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - directed self-checking bench for uart_frame_decoder
module tb_uart_frame_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        err_checksum;
    logic        err_timeout;
    logic [7:0]  error_count;

    always #5 clk = ~clk;

    uart_frame_decoder #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .error_count  (error_count)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_cmd = 0;
    int          n_echk = 0;
    int          n_etmo = 0;
    int          n_both = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  cap_addr = 8'h00;
    logic [31:0] cap_data = 32'h0;

    // Event monitor: counts command hand-outs and error pulses seen on falling edges.
    always @(negedge clk) begin
        if (cmd_valid && !prev_valid) begin
            n_cmd    = n_cmd + 1;
            cap_addr = cmd_addr;
            cap_data = cmd_data;
        end
        prev_valid = cmd_valid;
        if (err_checksum) n_echk = n_echk + 1;
        if (err_timeout)  n_etmo = n_etmo + 1;
        if (err_checksum && err_timeout) n_both = n_both + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_cmd  = 0;
        n_echk = 0;
        n_etmo = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check_eq("in_ready_wait", 32'(in_ready), 32'd1);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(d[7:0]);
        send_byte(d[15:8]);
        send_byte(d[23:16]);
        send_byte(d[31:24]);
        send_byte(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 clear_mon();
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int   hold_bad;
    int   guard;

    initial begin
        reset     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        cmd_ready = 1'b1;

        // Reset state
        settle(3);
        check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_err_chk",   32'(err_checksum), 32'd0);
        check_eq("rst_err_tmo",   32'(err_timeout), 32'd0);
        check_eq("rst_err_cnt",   32'(error_count), 32'd0);
        check_eq("rst_addr",      32'(cmd_addr), 32'd0);
        check_eq("rst_data",      cmd_data, 32'd0);
        check_eq("rst_in_ready",  32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 clear_mon();

        // Basic frame
        send_frame(8'h10, 32'hDEADBEEF, 8'h97);
        settle(4);
        check_eq("basic_ncmd", 32'(n_cmd), 32'd1);
        check_eq("basic_addr", 32'(cap_addr), 32'h10);
        check_eq("basic_data", cap_data, 32'hDEADBEEF);
        check_eq("basic_errcnt", 32'(error_count), 32'd0);
        check_eq("basic_valid_drop", 32'(cmd_valid), 32'd0);

        // Leading garbage, then a frame
        clear_mon();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        send_frame(8'h10, 32'hDEADBEEF, 8'h97);
        settle(4);
        check_eq("garb_ncmd", 32'(n_cmd), 32'd1);
        check_eq("garb_addr", 32'(cap_addr), 32'h10);
        check_eq("garb_data", cap_data, 32'hDEADBEEF);
        check_eq("garb_errs", 32'(n_echk + n_etmo), 32'd0);

        // Bad checksum
        do_reset();
        send_frame(8'h10, 32'hDEADBEEF, 8'h98);
        settle(4);
        check_eq("badchk_pulses", 32'(n_echk), 32'd1);
        check_eq("badchk_errcnt", 32'(error_count), 32'd1);
        check_eq("badchk_ncmd",   32'(n_cmd), 32'd0);

        // Backpressure, then second frame with A5 as payload/checksum
        clear_mon();
        cmd_ready = 1'b0;
        send_frame(8'h10, 32'hDEADBEEF, 8'h97);
        guard = 0;
        while (!cmd_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check_eq("bp_valid_up", 32'(cmd_valid), 32'd1);
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!cmd_valid || in_ready || cmd_addr !== 8'h10 || cmd_data !== 32'hDEADBEEF)
                hold_bad++;
        end
        check_eq("bp_hold", 32'(hold_bad), 32'd0);
        #1 check_eq("bp_ncmd", 32'(n_cmd), 32'd1);
        cmd_ready = 1'b1;
        send_frame(8'h01, 32'h00000001, 8'hA5);
        settle(4);
        check_eq("bp2_ncmd", 32'(n_cmd), 32'd2);
        check_eq("bp2_addr", 32'(cap_addr), 32'h01);
        check_eq("bp2_data", cap_data, 32'h00000001);

        // Timeout after A5 10 with 100-cycle limit
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h10);
        settle(99);
        check_eq("tmo_early", 32'(n_etmo), 32'd0);
        settle(2);
        check_eq("tmo_pulse", 32'(n_etmo), 32'd1);
        check_eq("tmo_errcnt", 32'(error_count), 32'd1);
        check_eq("tmo_in_ready", 32'(in_ready), 32'd1);
        settle(5);
        check_eq("tmo_single", 32'(n_etmo), 32'd1);
        send_frame(8'h10, 32'hDEADBEEF, 8'h97);
        settle(4);
        check_eq("tmo_next_ncmd", 32'(n_cmd), 32'd1);
        check_eq("tmo_next_data", cap_data, 32'hDEADBEEF);

        // Byte accepted on the limit cycle wins over the timeout
        clear_mon();
        send_byte(8'hA5);
        settle(98);
        send_byte(8'h22);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h83);
        settle(4);
        check_eq("edge_no_tmo", 32'(n_etmo), 32'd0);
        check_eq("edge_ncmd", 32'(n_cmd), 32'd1);
        check_eq("edge_addr", 32'(cap_addr), 32'h22);
        check_eq("edge_data", cap_data, 32'h04030201);

        // Reset mid-frame
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'hEF);
        @(negedge clk);
        reset = 1'b0;
        #1 check_eq("midrst_addr_async", 32'(cmd_addr), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send_frame(8'h10, 32'hDEADBEEF, 8'h97);
        settle(4);
        check_eq("midrst_ncmd", 32'(n_cmd), 32'd1);
        check_eq("midrst_addr", 32'(cap_addr), 32'h10);
        check_eq("midrst_data", cap_data, 32'hDEADBEEF);
        check_eq("midrst_errs", 32'(n_echk + n_etmo), 32'd0);
        check_eq("midrst_errcnt", 32'(error_count), 32'd0);

        // Error counter saturation
        do_reset();
        for (int i = 1; i <= 260; i++) begin
            send_frame(8'h00, 32'h0, 8'h00);
            if (i == 254) check_eq("sat_254", 32'(error_count), 32'hFE);
            if (i == 255) check_eq("sat_255", 32'(error_count), 32'hFF);
        end
        check_eq("sat_260", 32'(error_count), 32'hFF);

        settle(2);
        check_eq("never_both", 32'(n_both), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_decoder.md
UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 33_000, the maximum idle clk cycles allowed between bytes inside a frame (1 ms at 33 MHz).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port in_data  input  8  received byte from the UART receiver.
REQ-006 SHALL have port in_valid  input  1  in_data holds a byte.
REQ-007 SHALL have port in_ready  output  1  decoder accepts in_data this cycle.
REQ-008 SHALL have port cmd_addr  output  8  decoded frame address.
REQ-009 SHALL have port cmd_data  output  32  decoded frame payload.
REQ-010 SHALL have port cmd_valid  output  1  cmd_addr/cmd_data hold a verified command.
REQ-011 SHALL have port cmd_ready  input  1  consumer accepts the command.
REQ-012 SHALL have port err_checksum  output  1  one-cycle pulse on checksum mismatch.
REQ-013 SHALL have port err_timeout  output  1  one-cycle pulse on intra-frame timeout.
REQ-014 SHALL have port error_count  output  8  saturating count of all frame errors.

Function
REQ-015 SHALL define frame = SYNC_BYTE, addr, d0, d1, d2, d3, chk; cmd_data = {d3,d2,d1,d0}; chk = XOR of the six preceding bytes.
REQ-016 SHALL accept a byte only on a cycle with in_valid && in_ready.
REQ-017 SHALL implement states HUNT, ADDR, DATA, CHK, OUT; in_ready = 1 in all states except OUT.
REQ-018 HUNT: accepted byte == SYNC_BYTE -> ADDR, checksum register loaded with SYNC_BYTE; any other byte discarded, remain HUNT.
REQ-019 ADDR: accepted byte stored to cmd_addr, XORed into checksum -> DATA, byte index 0.
REQ-020 DATA: accepted byte stored to cmd_data[8*idx+7:8*idx], XORed into checksum, idx+1; after idx 3 -> CHK.
REQ-021 DATA: a byte equal to SYNC_BYTE SHALL be treated as payload, never as resynchronisation.
REQ-022 CHK: accepted byte == checksum -> OUT; else err_checksum pulses next cycle, error_count increments, -> HUNT.
REQ-023 cmd_valid SHALL be 1 exactly while in OUT, first asserted the cycle after the chk byte is accepted.
REQ-024 cmd_addr and cmd_data SHALL be stable while cmd_valid = 1.
REQ-025 OUT: on cmd_ready = 1 -> HUNT, cmd_valid = 0 next cycle; cmd_ready ignored when cmd_valid = 0.
REQ-026 Timeout counter SHALL run only in ADDR, DATA, CHK; cleared on every accepted byte and on entry to those states.
REQ-027 Counter reaching TIMEOUT_CYCLES-1 without an accepted byte -> HUNT, err_timeout pulses next cycle, error_count increments.
REQ-028 Byte accepted in the same cycle the counter reaches its limit: byte wins, no timeout.
REQ-029 error_count SHALL saturate at 8'hFF, never wrap.
REQ-030 err_checksum and err_timeout SHALL never pulse in the same cycle.

Reset
REQ-031 reset = 0 SHALL immediately force HUNT, cmd_valid = 0, err_checksum = 0, err_timeout = 0, error_count = 0, checksum = 0, timeout counter = 0, cmd_addr = 0, cmd_data = 0.
REQ-032 Reset mid-frame SHALL discard the partial frame with no error pulse or count.
REQ-033 After reset release, first accepted byte SHALL be processed in HUNT.

Verification
REQ-034 Bytes A5 10 EF BE AD DE 97, cmd_ready = 1 -> one cmd_valid pulse, cmd_addr = 8'h10, cmd_data = 32'hDEADBEEF, error_count = 0.
REQ-035 Bytes 00 FF 3C, then REQ-034 frame -> exactly one command, identical values, no error pulses.
REQ-036 REQ-034 frame with chk 98 -> err_checksum one pulse, error_count = 1, cmd_valid never 1.
REQ-037 REQ-034 frame, cmd_ready = 0 for 20 cycles -> cmd_valid held, outputs stable, in_ready = 0; then cmd_ready = 1 and second frame A5 01 01 00 00 00 A5 -> cmd_addr = 8'h01, cmd_data = 32'h00000001.
REQ-038 TIMEOUT_CYCLES = 100; bytes A5 10 then idle 100 cycles -> err_timeout one pulse, error_count = 1, HUNT; next full frame decodes normally.
REQ-039 reset = 0 after bytes A5 10 EF, release, then full REQ-034 frame -> one correct command, error_count = 0.
